// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM for a multi-cycle MIPS-style datapath.
//                Sequences fetch/decode/execute/memory/writeback steps,
//                stretches each memory access by MEM_LAT wait cycles and
//                drives the datapath control lines combinationally from
//                the current state, the wait counter and the ALU Zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_LAT = 2,       // memory wait cycles per access (0..7)
    parameter bit EN_ADDI = 1'b1     // 0: ADDI decodes as illegal
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       AWrite,
    output logic       BWrite,
    output logic       Break,
    output logic       Illegal,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp
);

    // State encoding; codes 14 and 15 are unused and recover to fetch.
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_RTYPE    = 4'd2;
    localparam logic [3:0] c_RTYPE_WB = 4'd3;
    localparam logic [3:0] c_ADDR     = 4'd4;
    localparam logic [3:0] c_LW_RD    = 4'd5;
    localparam logic [3:0] c_LW_WB    = 4'd6;
    localparam logic [3:0] c_SW_WR    = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_IMM      = 4'd9;
    localparam logic [3:0] c_IMM_WB   = 4'd10;
    localparam logic [3:0] c_J        = 4'd11;
    localparam logic [3:0] c_ILLEGAL  = 4'd12;
    localparam logic [3:0] c_BREAK    = 4'd13;

    // Opcode / funct values recognised by the decoder.
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_BREAK = 6'h0D;

    localparam logic [2:0] c_LAT = 3'(MEM_LAT);

    logic [3:0] r_state;
    logic [2:0] r_wait;
    logic [3:0] w_next;
    logic       w_wait_state;
    logic       w_last;

    // Memory-facing states stay put until the counter reaches MEM_LAT.
    assign w_wait_state = (r_state == c_FETCH) || (r_state == c_LW_RD) ||
                          (r_state == c_SW_WR);
    assign w_last       = (r_wait == c_LAT);

    // Next-state logic; Op/Funct are only looked at in DECODE, ADDR, BRANCH, IMM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:    if (w_last) w_next = c_DECODE;
            c_DECODE: begin
                case (Op)
                    c_OP_RTYPE:        w_next = (Funct == c_FN_BREAK) ? c_BREAK : c_RTYPE;
                    c_OP_BEQ, c_OP_BNE: w_next = c_BRANCH;
                    c_OP_LW, c_OP_SW:  w_next = c_ADDR;
                    c_OP_LUI:          w_next = c_IMM;
                    c_OP_ADDI:         w_next = (EN_ADDI != 1'b0) ? c_IMM : c_ILLEGAL;
                    c_OP_J:            w_next = c_J;
                    default:           w_next = c_ILLEGAL;
                endcase
            end
            c_RTYPE:    w_next = c_RTYPE_WB;
            c_RTYPE_WB: w_next = c_FETCH;
            c_ADDR:     w_next = (Op == c_OP_LW) ? c_LW_RD : c_SW_WR;
            c_LW_RD:    if (w_last) w_next = c_LW_WB;
            c_LW_WB:    w_next = c_FETCH;
            c_SW_WR:    if (w_last) w_next = c_FETCH;
            c_BRANCH:   w_next = c_FETCH;
            c_IMM:      w_next = c_IMM_WB;
            c_IMM_WB:   w_next = c_FETCH;
            c_J:        w_next = c_FETCH;
            c_ILLEGAL:  w_next = c_ILLEGAL;
            c_BREAK:    w_next = c_BREAK;
            default:    w_next = c_FETCH;
        endcase
    end

    // State and wait-counter registers; counter restarts on every state change.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_FETCH;
            r_wait  <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= 3'd0;
            else if (w_wait_state)
                r_wait <= r_wait + 3'd1;
        end
    end

    // Datapath control decode; everything defaults low unless the state sets it.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        IRWrite  = 1'b0;
        ALUSrcA  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        AWrite   = 1'b0;
        BWrite   = 1'b0;
        Break    = 1'b0;
        Illegal  = 1'b0;
        PCSource = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 3'b000;
        case (r_state)
            c_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR.
                ALUSrcB = 2'b01;
                IRWrite = w_last;
                PCWrite = w_last;
            end
            c_DECODE: begin
                AWrite  = 1'b1;
                BWrite  = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_RTYPE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            c_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            c_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_LW_RD: begin
                IorD = 1'b1;
            end
            c_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            c_SW_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            c_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                if (Op == c_OP_BEQ)
                    PCWrite = Zero;
                else if (Op == c_OP_BNE)
                    PCWrite = ~Zero;
            end
            c_IMM: begin
                ALUSrcA = 1'b1;
                if (Op == c_OP_LUI) begin
                    ALUSrcB = 2'b11;
                    ALUOp   = 3'b011;
                end else begin
                    ALUSrcB = 2'b10;
                    ALUOp   = 3'b000;
                end
            end
            c_IMM_WB: begin
                RegWrite = 1'b1;
            end
            c_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            c_ILLEGAL: begin
                Illegal = 1'b1;
            end
            c_BREAK: begin
                Break = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Three instances:
//                d0 MEM_LAT=2/ADDI on, d1 MEM_LAT=3/ADDI off, d2 MEM_LAT=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    typedef struct packed {
        logic pcw, iord, memw, m2r, irw, srca, regw, regdst, aw, bw, brk, ill;
        logic [1:0] pcs;
        logic [1:0] srcb;
        logic [2:0] aluop;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    hold;   // Op/Funct/Zero must carry the instruction in this cycle
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         len;
        int         n_pcw;
        int         n_regw;
        int         n_memw;
        int         n_iord;
    } vec_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [5:0] op_v    [3];
    logic [5:0] funct_v [3];
    logic [2:0] zero_v = 3'b000;

    logic [2:0] pcw_w, iord_w, memw_w, m2r_w, irw_w, srca_w, regw_w, regdst_w;
    logic [2:0] aw_w, bw_w, brk_w, ill_w;
    logic [1:0] pcs_w  [3];
    logic [1:0] srcb_w [3];
    logic [2:0] aluop_w[3];
    outs_t      dout   [3];

    int checks = 0;
    int errors = 0;

    step_t      expq[$];
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    logic       cur_z;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            multicycle_ctrl #(
                .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 3 : 0)),
                .EN_ADDI((g == 1) ? 1'b0 : 1'b1)
            ) u_dut (
                .Clk(clk), .Reset(rst_v[g]), .Op(op_v[g]), .Funct(funct_v[g]),
                .Zero(zero_v[g]), .PCWrite(pcw_w[g]), .IorD(iord_w[g]),
                .MemWrite(memw_w[g]), .MemtoReg(m2r_w[g]), .IRWrite(irw_w[g]),
                .ALUSrcA(srca_w[g]), .RegWrite(regw_w[g]), .RegDst(regdst_w[g]),
                .AWrite(aw_w[g]), .BWrite(bw_w[g]), .Break(brk_w[g]),
                .Illegal(ill_w[g]), .PCSource(pcs_w[g]), .ALUSrcB(srcb_w[g]),
                .ALUOp(aluop_w[g])
            );
            assign dout[g] = {pcw_w[g], iord_w[g], memw_w[g], m2r_w[g], irw_w[g],
                              srca_w[g], regw_w[g], regdst_w[g], aw_w[g], bw_w[g],
                              brk_w[g], ill_w[g], pcs_w[g], srcb_w[g], aluop_w[g]};
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-edge reset; returns just after the edge with the DUT in FETCH, count 0.
    task automatic do_reset(input int g);
        rst_v[g] = 1'b1;
        step();
        rst_v[g] = 1'b0;
    endtask

    function automatic void push(input outs_t o, input bit h);
        step_t s;
        s.o = o;
        s.hold = h;
        expq.push_back(s);
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input bit en);
        return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h05) ||
               (op == 6'h0F) || (op == 6'h23) || (op == 6'h2B) ||
               ((op == 6'h08) && en);
    endfunction

    // Reference model: per-cycle expected outputs of one instruction, from
    // its class and the memory latency.
    function automatic void gen(input int lat, input bit en, input logic [5:0] op,
                                input logic [5:0] fn, input logic z);
        outs_t o;
        expq.delete();
        for (int i = 0; i <= lat; i++) begin
            o = '0; o.srcb = 2'b01; o.irw = (i == lat); o.pcw = (i == lat);
            push(o, 1'b0);
        end
        o = '0; o.aw = 1'b1; o.bw = 1'b1; o.srcb = 2'b10;
        push(o, 1'b1);
        if (op == 6'h00 && fn == 6'h0D) begin
            o = '0; o.brk = 1'b1;
            for (int i = 0; i < 10; i++) push(o, 1'b0);
        end else if (op == 6'h00) begin
            o = '0; o.srca = 1'b1; o.aluop = 3'b010; push(o, 1'b0);
            o = '0; o.regw = 1'b1; o.regdst = 1'b1; push(o, 1'b0);
        end else if (op == 6'h04 || op == 6'h05) begin
            o = '0; o.srca = 1'b1; o.aluop = 3'b001; o.pcs = 2'b01;
            o.pcw = (op == 6'h04) ? z : ~z;
            push(o, 1'b1);
        end else if (op == 6'h23 || op == 6'h2B) begin
            o = '0; o.srca = 1'b1; o.srcb = 2'b10; push(o, 1'b1);
            for (int i = 0; i <= lat; i++) begin
                o = '0; o.iord = 1'b1; o.memw = (op == 6'h2B); push(o, 1'b0);
            end
            if (op == 6'h23) begin
                o = '0; o.regw = 1'b1; o.m2r = 1'b1; push(o, 1'b0);
            end
        end else if (op == 6'h0F || (op == 6'h08 && en)) begin
            o = '0; o.srca = 1'b1;
            o.srcb  = (op == 6'h0F) ? 2'b11 : 2'b10;
            o.aluop = (op == 6'h0F) ? 3'b011 : 3'b000;
            push(o, 1'b1);
            o = '0; o.regw = 1'b1; push(o, 1'b0);
        end else if (op == 6'h02) begin
            o = '0; o.pcw = 1'b1; o.pcs = 2'b10; push(o, 1'b0);
        end else begin
            o = '0; o.ill = 1'b1;
            for (int i = 0; i < 10; i++) push(o, 1'b0);
        end
    endfunction

    // Play the model queue; inputs outside hold cycles are scrambled.
    task automatic run_queue(input int g, input int tag);
        foreach (expq[i]) begin
            if (expq[i].hold) begin
                op_v[g] = cur_op; funct_v[g] = cur_fn; zero_v[g] = cur_z;
            end else begin
                op_v[g] = 6'($urandom); funct_v[g] = 6'($urandom); zero_v[g] = 1'($urandom);
            end
            @(negedge clk);
            check($sformatf("trace_d%0d_i%0d_c%0d", g, tag, i), 32'(dout[g]), 32'(expq[i].o));
            step();
        end
    endtask

    task automatic run_random(input int g, input int lat, input bit en, input int n);
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h08, 6'h02};
        do_reset(g);
        for (int k = 0; k < n; k++) begin
            cur_op = ops[$urandom_range(0, 7)];
            if (cur_op == 6'h08 && !en) cur_op = 6'h00;
            cur_fn = 6'($urandom);
            if (cur_fn == 6'h0D) cur_fn = 6'h20;
            cur_z = 1'($urandom);
            gen(lat, en, cur_op, cur_fn, cur_z);
            run_queue(g, k);
        end
        if ($urandom_range(0, 1) == 1) begin
            cur_op = 6'h00; cur_fn = 6'h0D;
        end else begin
            do cur_op = 6'($urandom); while (is_legal(cur_op, en));
            cur_fn = 6'($urandom);
        end
        cur_z = 1'($urandom);
        gen(lat, en, cur_op, cur_fn, cur_z);
        run_queue(g, n);
    endtask

    // Table entry on d0 (MEM_LAT=2): activity counts over the instruction
    // window, then the following cycle must be the first fetch cycle.
    task automatic apply_vec(input int idx, input vec_t v);
        int npcw, nregw, nmemw, niord, nirw;
        outs_t fs;
        npcw = 0; nregw = 0; nmemw = 0; niord = 0; nirw = 0;
        do_reset(0);
        op_v[0] = v.op; funct_v[0] = v.funct; zero_v[0] = v.zero;
        for (int c = 0; c < v.len; c++) begin
            @(negedge clk);
            npcw  += int'(dout[0].pcw);
            nregw += int'(dout[0].regw);
            nmemw += int'(dout[0].memw);
            niord += int'(dout[0].iord);
            nirw  += int'(dout[0].irw);
            step();
        end
        @(negedge clk);
        fs = '0; fs.srcb = 2'b01;
        check($sformatf("vec%0d_next_fetch", idx), 32'(dout[0]), 32'(fs));
        check($sformatf("vec%0d_pcw", idx),  32'(npcw),  32'(v.n_pcw));
        check($sformatf("vec%0d_regw", idx), 32'(nregw), 32'(v.n_regw));
        check($sformatf("vec%0d_memw", idx), 32'(nmemw), 32'(v.n_memw));
        check($sformatf("vec%0d_iord", idx), 32'(niord), 32'(v.n_iord));
        check($sformatf("vec%0d_irw", idx),  32'(nirw),  32'd1);
    endtask

    initial begin
        vec_t  vecs [10];
        outs_t e;
        logic [8:0] irw_m, wb_m;
        logic [3:0] f_m;

        vecs[0] = '{6'h00, 6'h20, 1'b0, 6, 1, 1, 0, 0};
        vecs[1] = '{6'h23, 6'h00, 1'b0, 9, 1, 1, 0, 3};
        vecs[2] = '{6'h2B, 6'h00, 1'b0, 8, 1, 0, 3, 3};
        vecs[3] = '{6'h04, 6'h00, 1'b1, 5, 2, 0, 0, 0};
        vecs[4] = '{6'h04, 6'h00, 1'b0, 5, 1, 0, 0, 0};
        vecs[5] = '{6'h05, 6'h00, 1'b1, 5, 1, 0, 0, 0};
        vecs[6] = '{6'h05, 6'h00, 1'b0, 5, 2, 0, 0, 0};
        vecs[7] = '{6'h0F, 6'h00, 1'b0, 6, 1, 1, 0, 0};
        vecs[8] = '{6'h08, 6'h00, 1'b0, 6, 1, 1, 0, 0};
        vecs[9] = '{6'h02, 6'h00, 1'b0, 5, 2, 0, 0, 0};

        for (int g = 0; g < 3; g++) begin
            op_v[g] = 6'h00; funct_v[g] = 6'h00;
        end
        step();
        step();

        // Reset state, with and without memory wait.
        do_reset(0);
        @(negedge clk);
        e = '0; e.srcb = 2'b01;
        check("reset_d0", 32'(dout[0]), 32'(e));
        do_reset(2);
        @(negedge clk);
        e = '0; e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        check("reset_d2_lat0", 32'(dout[2]), 32'(e));
        rst_v[2] = 1'b1;

        for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

        // R-type timeline at MEM_LAT=2 (cycles 1..9).
        do_reset(0);
        op_v[0] = 6'h00; funct_v[0] = 6'h20;
        irw_m = '0; wb_m = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            irw_m[c] = dout[0].irw & dout[0].pcw;
            wb_m[c]  = dout[0].regw & dout[0].regdst;
            step();
        end
        check("rtype_irw_cycles", 32'(irw_m), 32'h104);
        check("rtype_wb_cycles",  32'(wb_m),  32'h020);

        // Illegal hold, mid-cycle reset glitch ignored, then break hold.
        do_reset(0);
        op_v[0] = 6'h3F; funct_v[0] = 6'h00;
        repeat (4) step();
        for (int c = 0; c < 10; c++) begin
            op_v[0] = 6'($urandom); funct_v[0] = 6'($urandom);
            @(negedge clk);
            check($sformatf("illegal_hold_c%0d", c),
                  {24'd0, dout[0].ill, dout[0].brk, dout[0].pcw, dout[0].memw,
                   dout[0].irw, dout[0].regw, dout[0].aw, dout[0].bw}, 32'h80);
            step();
        end
        #1 rst_v[0] = 1'b1;
        #2 rst_v[0] = 1'b0;
        @(negedge clk);
        check("illegal_after_glitch", 32'(dout[0].ill), 32'd1);
        step();
        do_reset(0);
        op_v[0] = 6'h00; funct_v[0] = 6'h0D;
        repeat (4) step();
        for (int c = 0; c < 10; c++) begin
            op_v[0] = 6'($urandom); funct_v[0] = 6'($urandom);
            @(negedge clk);
            check($sformatf("break_hold_c%0d", c),
                  {24'd0, dout[0].ill, dout[0].brk, dout[0].pcw, dout[0].memw,
                   dout[0].irw, dout[0].regw, dout[0].aw, dout[0].bw}, 32'h40);
            step();
        end
        rst_v[0] = 1'b1;

        // Reset in the second SW_WR cycle at MEM_LAT=3.
        do_reset(1);
        op_v[1] = 6'h2B; funct_v[1] = 6'h00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 7) check($sformatf("sw_memw_c%0d", c), 32'(dout[1].memw), 32'd1);
            if (c < 8) step();
        end
        rst_v[1] = 1'b1;
        step();
        rst_v[1] = 1'b0;
        f_m = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                e = '0; e.srcb = 2'b01;
                check("sw_reset_fetch", 32'(dout[1]), 32'(e));
            end
            f_m[c] = dout[1].irw;
            step();
        end
        check("sw_reset_fetch_len", 32'(f_m), 32'h8);

        // ADDI with decode disabled goes illegal.
        do_reset(1);
        op_v[1] = 6'h08;
        repeat (5) step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("addi_off_ill_c%0d", c), 32'(dout[1].ill), 32'd1);
            step();
        end
        rst_v[1] = 1'b1;

        // Randomized instruction streams against the reference model.
        run_random(0, 2, 1'b1, 30);
        rst_v[0] = 1'b1;
        run_random(1, 3, 1'b0, 30);
        rst_v[1] = 1'b1;
        run_random(2, 0, 1'b1, 30);
        rst_v[2] = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2, memory wait cycles per access (legal 0..7).
REQ-002 Parameter EN_ADDI, default 1, enables ADDI decode (0 = ADDI treated as illegal).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Op  input  6  instruction opcode field IR[31:26].
REQ-006 Funct  input  6  R-type funct field IR[5:0].
REQ-007 Zero  input  1  ALU zero flag, combinational, valid in BRANCH state.
REQ-008 Outputs, 1 bit each: PCWrite, IorD, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, AWrite, BWrite, Break, Illegal.
REQ-009 Outputs: PCSource (2: 00 ALU, 01 ALUOut, 10 jump), ALUSrcB (2: 00 B, 01 const 4, 10 sign-ext imm, 11 imm<<16).
REQ-010 ALUOp output, 3 bits: 000 add, 001 sub, 010 funct-decoded, 011 pass B.

Function
REQ-011 States SHALL be FETCH, DECODE, RTYPE, RTYPE_WB, ADDR, LW_RD, LW_WB, SW_WR, BRANCH, IMM, IMM_WB, J, ILLEGAL, BREAK.
REQ-012 Outputs SHALL be combinational from state, wait counter and Zero; every output 0 unless listed for the state.
REQ-013 A 3-bit wait counter SHALL make FETCH, LW_RD, SW_WR each last exactly MEM_LAT+1 cycles; cleared on every state change.
REQ-014 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000; IRWrite=1 and PCWrite=1 (PCSource=00) only in the final cycle; then DECODE.
REQ-015 DECODE: AWrite=1, BWrite=1, ALUSrcA=0, ALUSrcB=10, ALUOp=000 (branch target); next by Op.
REQ-016 DECODE map: 0x00 with Funct=0x0D -> BREAK; other 0x00 -> RTYPE; 0x04/0x05 -> BRANCH; 0x23/0x2B -> ADDR; 0x0F -> IMM; 0x08 -> IMM if EN_ADDI else ILLEGAL; 0x02 -> J; anything else -> ILLEGAL.
REQ-017 RTYPE: ALUSrcA=1, ALUSrcB=00, ALUOp=010; then RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
REQ-018 ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; Op 0x23 -> LW_RD, 0x2B -> SW_WR.
REQ-019 LW_RD: IorD=1, MemWrite=0; then LW_WB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-020 SW_WR: IorD=1, MemWrite=1 every cycle of the state; then FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWrite=Zero for Op 0x04, PCWrite=!Zero for Op 0x05; then FETCH.
REQ-022 IMM: ALUSrcA=1; Op 0x0F -> ALUSrcB=11, ALUOp=011; Op 0x08 -> ALUSrcB=10, ALUOp=000; then IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-023 J: PCWrite=1, PCSource=10; then FETCH.
REQ-024 ILLEGAL: Illegal=1, all write enables 0, state held until Reset.
REQ-025 BREAK: Break=1, all write enables 0, state held until Reset.
REQ-026 Op and Funct SHALL be sampled only in DECODE, ADDR, BRANCH and IMM; changes elsewhere ignored.
REQ-027 Cycles per instruction SHALL be: R-type/IMM 4+MEM_LAT, BRANCH/J 3+MEM_LAT, LW 5+2*MEM_LAT, SW 4+2*MEM_LAT.
REQ-028 Unreachable state encodings SHALL go to FETCH next cycle with all outputs 0.

Reset
REQ-029 Reset=1 at a rising edge SHALL force FETCH with counter 0, overriding every state incl. BREAK and ILLEGAL and any mid-wait count.
REQ-030 While in FETCH after reset with counter 0, outputs SHALL be IorD=0, ALUSrcB=01, all write enables, Break, Illegal 0 (unless MEM_LAT=0, then IRWrite=PCWrite=1).
REQ-031 No output SHALL depend on asynchronous Reset; Reset asserted between edges has no effect until the next edge.

Verification
REQ-032 MEM_LAT=2, Op=0x00 Funct=0x20 -> IRWrite/PCWrite high only in cycle 3, RegWrite+RegDst in cycle 6, FETCH re-entered cycle 7.
REQ-033 MEM_LAT=2, Op=0x23 -> IorD=1 for 3 consecutive cycles in LW_RD, then one cycle RegWrite=1 MemtoReg=1; total 9 cycles.
REQ-034 Op=0x05 with Zero=1 -> PCWrite stays 0 in BRANCH; repeat with Zero=0 -> PCWrite=1, PCSource=01 for one cycle.
REQ-035 Op=0x3F, then Op=0x00 Funct=0x0D (after reset) -> Illegal=1 held, then Break=1 held, 10 cycles each, no write enable toggles.
REQ-036 Reset pulsed in second cycle of SW_WR (MEM_LAT=3) -> MemWrite=0 next cycle, state FETCH, counter 0.
REQ-037 EN_ADDI=0, Op=0x08 -> ILLEGAL; EN_ADDI=1, Op=0x08 -> IMM with ALUSrcB=10, then RegWrite=1.
